// File: rtl/store_mem_fu.sv
// store_mem_fu
//   Store memory functional unit. Takes one committed, operand-ready store
//   from the store reservation station per issue pulse. It forms the
//   word-aligned address, the byte write mask and the lane-shifted write data.
//   It then holds the data-memory write request until dmem_resp and reports
//   the finished store as an RVFI-style record.
//
// Optional feature macro: STORE_FU_MISALIGN_CHK_EN
//   When defined, a misaligned sh/sw is not written to memory. It completes
//   through DONE with st_misalign. When undefined, st_misalign is tied low
//   and misaligned sh/sw use the aligned lane formulas.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   issue        store entry valid (single-cycle pulse)
//   entry_in     {rs1_data, rs2_data, imm_value, funct3}
//   fu_running   busy; high exactly in REQ cycles (registered)
//   dmem_addr    word-aligned store address
//   dmem_rmask   always 0
//   dmem_wmask   byte write enables, non-zero only in REQ
//   dmem_wdata   lane-shifted store data
//   dmem_resp    memory write acknowledge
//   st_done      one-cycle completion pulse
//   st_rvfi      {addr, rmask, rdata, wmask, wdata}, valid with st_done
//   st_misalign  misaligned-store pulse with st_done (feature macro only)
module store_mem_fu #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  logic [3*ADDR_W+2:0] entry_in,
  output logic                fu_running,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [3:0]          dmem_rmask,
  output logic [3:0]          dmem_wmask,
  output logic [ADDR_W-1:0]   dmem_wdata,
  input  logic                dmem_resp,
  output logic                st_done,
  output logic [3*ADDR_W+7:0] st_rvfi,
  output logic                st_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  state_t state, state_n;

  logic [ADDR_W-1:0] rs1_data, rs2_data, imm_value;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr_c;
  logic              valid_f3, mis_c, go_req, accept;

  logic [ADDR_W-1:0] addr_q, wdata_q;
  logic [3:0]        wmask_q;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << {off[1], 1'b0};
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] lane_data(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [ADDR_W-1:0] rs2);
    case (f3)
      F3_SB:   return {{(ADDR_W-8){1'b0}}, rs2[7:0]} << {off, 3'b000};
      F3_SH:   return {{(ADDR_W-16){1'b0}}, rs2[15:0]} << {off[1], 4'b0000};
      F3_SW:   return rs2;
      default: return '0;
    endcase
  endfunction

  assign rs1_data  = entry_in[3*ADDR_W+2 -: ADDR_W];
  assign rs2_data  = entry_in[2*ADDR_W+2 -: ADDR_W];
  assign imm_value = entry_in[ADDR_W+2 -: ADDR_W];
  assign funct3    = entry_in[2:0];

  assign addr_c   = rs1_data + imm_value;
  assign valid_f3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);

`ifdef STORE_FU_MISALIGN_CHK_EN
  assign mis_c = ((funct3 == F3_SH) && addr_c[0]) ||
                 ((funct3 == F3_SW) && (addr_c[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Stores with a bad funct3 or a rejected alignment skip REQ and only report.
  assign go_req = valid_f3 && !mis_c;
  // A new entry is taken in IDLE and DONE. An issue during REQ is dropped.
  assign accept = issue && (state != REQ);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (issue) state_n = go_req ? REQ : DONE;
        else       state_n = IDLE;
      end
      REQ:     if (dmem_resp) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fu_running <= 1'b0;
      addr_q     <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_n;
      fu_running <= (state_n == REQ);
      if (accept) begin
        addr_q  <= addr_c;
        wmask_q <= go_req ? lane_mask(funct3, addr_c[1:0]) : 4'b0000;
        wdata_q <= go_req ? lane_data(funct3, addr_c[1:0], rs2_data) : '0;
      end
    end
  end

`ifdef STORE_FU_MISALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst)         misalign_q <= 1'b0;
    else if (accept) misalign_q <= mis_c;
  end
  assign st_misalign = (state == DONE) && misalign_q;
`else
  assign st_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issue && state == REQ))
        else $warning("store_mem_fu: issue while a store is in flight was ignored");
    end
  end

  // Output stage: the request fields are held in registers and gated by state.
  assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_rmask = 4'b0000;
  assign dmem_wmask = (state == REQ) ? wmask_q : 4'b0000;
  assign dmem_wdata = wdata_q;
  assign st_done    = (state == DONE);
  // rdata is a don't-care for stores and is reported as zero.
  assign st_rvfi    = (state == DONE) ? {addr_q, 4'b0000, {ADDR_W{1'b0}}, wmask_q, wdata_q} : '0;

endmodule

// File: tb/tb_store_mem_fu.sv
module tb_store_mem_fu;

  logic         clk = 1'b0;
  logic         rst, issue, dmem_resp;
  logic [98:0]  entry_in;
  logic         fu_running, st_done, st_misalign;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic [3:0]   dmem_rmask, dmem_wmask;
  logic [103:0] st_rvfi;

  int n_chk  = 0;
  int n_fail = 0;

  store_mem_fu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .issue(issue), .entry_in(entry_in),
    .fu_running(fu_running), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
    .st_done(st_done), .st_rvfi(st_rvfi), .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  wire [31:0] rv_addr  = st_rvfi[103:72];
  wire [3:0]  rv_rmask = st_rvfi[71:68];
  wire [3:0]  rv_wmask = st_rvfi[35:32];
  wire [31:0] rv_wdata = st_rvfi[31:0];

  typedef struct {
    logic [31:0] rs1, rs2, imm;
    logic [2:0]  f3;
    int          waits;
    logic        skip, mis;
    logic [31:0] addr, full;
    logic [3:0]  wm;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] rs1, rs2, imm, input logic [2:0] f3,
                              input int waits, input logic skip, mis,
                              input logic [31:0] addr, full, input logic [3:0] wm,
                              input logic [31:0] wd);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.f3 = f3; v.waits = waits;
    v.skip = skip; v.mis = mis; v.addr = addr; v.full = full; v.wm = wm; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_issue(input logic [31:0] rs1, rs2, imm, input logic [2:0] f3);
    @(negedge clk);
    issue    = 1'b1;
    entry_in = {rs1, rs2, imm, f3};
    @(negedge clk);
    issue    = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_issue(v.rs1, v.rs2, v.imm, v.f3);
    if (v.skip) begin
      chk($sformatf("v%0d skip done", idx), st_done, 1'b1);
      chk($sformatf("v%0d skip running", idx), fu_running, 1'b0);
      chk($sformatf("v%0d skip wmask", idx), dmem_wmask, 4'h0);
      chk($sformatf("v%0d skip rvfi_wmask", idx), rv_wmask, 4'h0);
      chk($sformatf("v%0d skip rvfi_addr", idx), rv_addr, v.full);
      chk($sformatf("v%0d skip misalign", idx), st_misalign, v.mis);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        chk($sformatf("v%0d req%0d running", idx, w), fu_running, 1'b1);
        chk($sformatf("v%0d req%0d addr", idx, w), dmem_addr, v.addr);
        chk($sformatf("v%0d req%0d wmask", idx, w), dmem_wmask, v.wm);
        chk($sformatf("v%0d req%0d wdata", idx, w), dmem_wdata, v.wd);
        chk($sformatf("v%0d req%0d done", idx, w), st_done, 1'b0);
        if (w == v.waits) dmem_resp = 1'b1;
        @(negedge clk);
      end
      dmem_resp = 1'b0;
      chk($sformatf("v%0d done", idx), st_done, 1'b1);
      chk($sformatf("v%0d done running", idx), fu_running, 1'b0);
      chk($sformatf("v%0d done wmask", idx), dmem_wmask, 4'h0);
      chk($sformatf("v%0d rvfi_addr", idx), rv_addr, v.full);
      chk($sformatf("v%0d rvfi_wmask", idx), rv_wmask, v.wm);
      chk($sformatf("v%0d rvfi_wdata", idx), rv_wdata, v.wd);
      chk($sformatf("v%0d rvfi_rmask", idx), rv_rmask, 4'h0);
      chk($sformatf("v%0d misalign", idx), st_misalign, 1'b0);
    end
    @(negedge clk);
    chk($sformatf("v%0d done clears", idx), st_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; dmem_resp = 1'b0; entry_in = '0;

    //        rs1           rs2           imm           f3      w  sk mis addr          full          wm     wd
    vecs[0] = mk(32'h00001000, 32'h000000AB, 32'h00000003, 3'b000, 3, 0, 0, 32'h00001000, 32'h00001003, 4'b1000, 32'hAB000000);
    vecs[1] = mk(32'h00002000, 32'h1234CAFE, 32'h00000002, 3'b001, 0, 0, 0, 32'h00002000, 32'h00002002, 4'b1100, 32'hCAFE0000);
    vecs[2] = mk(32'h00000011, 32'hDEADBEEF, 32'hFFFFFFFF, 3'b000, 1, 0, 0, 32'h00000010, 32'h00000010, 4'b0001, 32'h000000EF);
    vecs[3] = mk(32'h00003000, 32'hFFFF5678, 32'h00000000, 3'b001, 2, 0, 0, 32'h00003000, 32'h00003000, 4'b0011, 32'h00005678);
    vecs[4] = mk(32'h00004000, 32'hCAFEBABE, 32'h00000004, 3'b010, 0, 0, 0, 32'h00004004, 32'h00004004, 4'b1111, 32'hCAFEBABE);
    vecs[5] = mk(32'h00000100, 32'h00000077, 32'h00000001, 3'b000, 0, 0, 0, 32'h00000100, 32'h00000101, 4'b0010, 32'h00007700);
    vecs[6] = mk(32'h00000100, 32'h00000077, 32'h00000002, 3'b000, 0, 0, 0, 32'h00000100, 32'h00000102, 4'b0100, 32'h00770000);
    vecs[7] = mk(32'h00000050, 32'h12345678, 32'h00000000, 3'b011, 0, 1, 0, 32'h00000050, 32'h00000050, 4'b0000, 32'h00000000);
`ifdef STORE_FU_MISALIGN_CHK_EN
    vecs[8] = mk(32'h00001000, 32'h11223344, 32'h00000001, 3'b010, 0, 1, 1, 32'h00001000, 32'h00001001, 4'b0000, 32'h00000000);
    vecs[9] = mk(32'h00002000, 32'hAAAA5566, 32'h00000001, 3'b001, 0, 1, 1, 32'h00002000, 32'h00002001, 4'b0000, 32'h00000000);
`else
    vecs[8] = mk(32'h00001000, 32'h11223344, 32'h00000001, 3'b010, 1, 0, 0, 32'h00001000, 32'h00001001, 4'b1111, 32'h11223344);
    vecs[9] = mk(32'h00002000, 32'hAAAA5566, 32'h00000001, 3'b001, 0, 0, 0, 32'h00002000, 32'h00002001, 4'b0011, 32'h00005566);
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst running", fu_running, 1'b0);
    chk("rst addr", dmem_addr, 32'h0);
    chk("rst wmask", dmem_wmask, 4'h0);
    chk("rst rmask", dmem_rmask, 4'h0);
    chk("rst wdata", dmem_wdata, 32'h0);
    chk("rst done", st_done, 1'b0);
    chk("rst misalign", st_misalign, 1'b0);
    chk("rst rvfi", st_rvfi, 104'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back sw with zero-wait responses; second issue in first DONE
    drive_issue(32'h00005000, 32'h01020304, 32'h0, 3'b010);
    chk("b2b req1 running", fu_running, 1'b1);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("b2b done1", st_done, 1'b1);
    chk("b2b done1 addr", rv_addr, 32'h00005000);
    issue = 1'b1; entry_in = {32'h00006000, 32'h0A0B0C0D, 32'h8, 3'b010};
    @(negedge clk);
    issue = 1'b0;
    chk("b2b req2 running", fu_running, 1'b1);
    chk("b2b req2 done low", st_done, 1'b0);
    chk("b2b req2 addr", dmem_addr, 32'h00006008);
    chk("b2b req2 wdata", dmem_wdata, 32'h0A0B0C0D);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("b2b done2", st_done, 1'b1);
    chk("b2b done2 addr", rv_addr, 32'h00006008);
    chk("b2b done2 wdata", rv_wdata, 32'h0A0B0C0D);
    @(negedge clk);

    // Issue during REQ is ignored
    drive_issue(32'h00007000, 32'h000000C3, 32'h1, 3'b000);
    issue = 1'b1; entry_in = {32'h00008000, 32'hFFFFFFFF, 32'h0, 3'b010};
    @(negedge clk);
    issue = 1'b0;
    chk("ign running", fu_running, 1'b1);
    chk("ign addr", dmem_addr, 32'h00007000);
    chk("ign wmask", dmem_wmask, 4'b0010);
    chk("ign wdata", dmem_wdata, 32'h0000C300);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("ign done", st_done, 1'b1);
    chk("ign rvfi addr", rv_addr, 32'h00007001);
    chk("ign rvfi wmask", rv_wmask, 4'b0010);
    @(negedge clk);
    chk("ign back idle", fu_running, 1'b0);

    // Reset mid-REQ abandons the store
    drive_issue(32'h00009000, 32'h55555555, 32'h0, 3'b010);
    chk("mrst req running", fu_running, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst running", fu_running, 1'b0);
    chk("mrst wmask", dmem_wmask, 4'h0);
    chk("mrst done", st_done, 1'b0);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mrst no done %0d", k), st_done, 1'b0);
      chk($sformatf("mrst idle %0d", k), fu_running, 1'b0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_mem_fu.md
# store_mem_fu

Store memory functional unit: the consumer end of the store reservation station's issue interface. Accepts one committed, operand-ready store entry per `issue` pulse, forms the word-aligned address, byte write mask and lane-shifted write data, and runs the data-memory write handshake until `dmem_resp`. While a store is in flight, `fu_running` holds off further issue. On completion it reports the store via an RVFI-style record. Sits between the store reservation station and the data-cache port arbiter.

## Interface
- `ADDR_W`, 32, address/data width (fixed at 32 for RV32I; other values unsupported)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `issue`  in  1  entry valid this cycle (single-cycle pulse from the reservation station)
- `entry_in`  in  `$bits(ResEntrySt_reg_t)`  store entry; uses `rs1_data`, `rs2_data`, `imm_value`, `funct3`
- `fu_running`  out  1  unit busy; the station must not issue while high
- `dmem_addr`  out  32  word-aligned address (`addr & ~32'h3`)
- `dmem_rmask`  out  4  always `4'b0000`
- `dmem_wmask`  out  4  byte write enables; non-zero only in state REQ
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_resp`  in  1  memory write acknowledge
- `st_done`  out  1  one-cycle completion pulse
- `st_rvfi`  out  `$bits(mem_rvfi)`  `{addr, rmask=0, rdata='x, wmask, wdata}` of the completed store; valid while `st_done`
- `st_misalign`  out  1  one-cycle pulse, only with `STORE_FU_MISALIGN_CHK_EN`

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `fu_running`=0. `issue`=1 latches the entry: `addr = rs1_data + imm_value` (mod 2^32), then computes mask/data. Next state is REQ.
- Mask/data by `funct3`:
  - sb: `wmask = 4'b0001 << addr[1:0]`; `wdata = {24'b0, rs2[7:0]} << 8*addr[1:0]`
  - sh: `wmask = 4'b0011 << 2*addr[1]`; `wdata = {16'b0, rs2[15:0]} << 16*addr[1]`
  - sw: `wmask = 4'b1111`; `wdata = rs2`
  - Unmasked bytes of `wdata` are 0.
- Any other `funct3`: wmask = 0. Go directly to DONE with no memory request, and report `st_rvfi` with wmask 0.
- REQ: `fu_running`=1. `dmem_addr`, `dmem_wmask` and `dmem_wdata` are held stable every cycle until the cycle `dmem_resp`=1 inclusive, then the FSM goes to DONE.
- DONE: `st_done`=1 and `st_rvfi` driven, for exactly one cycle. `fu_running`=0 and `dmem_wmask`=0. Next state is IDLE. An `issue` in DONE is accepted exactly as in IDLE, so DONE→REQ directly.
- `issue` while in REQ is a protocol violation: it is ignored, and a simulation assertion fires.
- `dmem_resp` outside REQ is ignored.
- No flush input: issued stores are already committed and always complete.

## Timing
- Reset values: FSM=IDLE; `fu_running`=0, `dmem_addr`=0, `dmem_wmask`=0, `dmem_rmask`=0, `dmem_wdata`=0, `st_done`=0, `st_misalign`=0, `st_rvfi`=0.
- `issue` in cycle T → REQ outputs valid from cycle T+1.
- `dmem_resp` in cycle R → `st_done` in cycle R+1.
- Minimum occupancy: issue T, resp T+1, done T+2, next issue accepted in T+2 (back-to-back throughput of 1 store per 2 cycles plus memory latency).
- `fu_running` is a registered output: high exactly in REQ cycles.
- `rst` mid-operation: the FSM drops to IDLE at the next edge, the in-flight store is abandoned, and no `st_done` is produced.
- `dmem_resp` in the same cycle REQ is first entered is legal (zero-wait memory).

## Configuration
- `STORE_FU_MISALIGN_CHK_EN` defined:
  - Misaligned cases are sh with `addr[0]=1`, and sw with `addr[1:0]≠0`.
  - A misaligned store skips REQ and goes IDLE→DONE.
  - In DONE it pulses `st_misalign` together with `st_done`; `st_rvfi.wmask` = 0 and no memory write occurs.
- Not defined:
  - `st_misalign` is tied to 0.
  - Misaligned sh/sw are written using the aligned lane formulas above (low address bits ignored beyond the lane select).

## Test plan
- Reset mid-REQ (`dmem_resp` withheld) → next cycle `fu_running`=0, `dmem_wmask`=0; no `st_done` ever follows.
- sb, rs1=0x1000, imm=3, rs2=0xAB → `dmem_addr`=0x1000, `wmask`=4'b1000, `wdata`=0xAB000000, held for 3 wait cycles until resp; `st_done` the next cycle, with `st_rvfi.addr`=0x1003.
- sh, rs1=0x2000, imm=2, rs2=0x1234CAFE → `wmask`=4'b1100, `wdata`=0xCAFE0000.
- Two sw back-to-back, `issue` asserted in the DONE cycle of the first, zero-wait `dmem_resp` → second REQ begins the cycle after the first DONE; two `st_done` pulses 2 cycles apart.
- `issue` during REQ → ignored, assertion fires, first store's outputs unchanged.
- With `STORE_FU_MISALIGN_CHK_EN`, sw to 0x1001 → no REQ cycle (`dmem_wmask` stays 0); `st_done`=`st_misalign`=1 at T+1. Without the macro → REQ with addr 0x1000, `wmask`=4'b1111.
